// File: rtl/datablock_fifo_if.sv
// Handshake bundle between the address/data block, the FIFO
// and the next stage.
interface datablock_fifo_if #(
  parameter int WIDTH = 2,
  parameter int AW    = 2
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [AW-1:0]    wr_addr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  wr_addr, count, full, empty
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output wr_addr, count, full, empty
  );
endinterface

// File: rtl/datablock_fifo.sv
// First-word fall-through FIFO behind the 2-bit address/data block.
// Optional push counter enabled by DATABLOCK_FIFO_STATS_EN.
module datablock_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DATABLOCK_FIFO_STATS_EN
  input  logic       stats_clr,
  output logic [7:0] push_total,
`endif
  datablock_fifo_if.slave bus
);

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  assign w_push = bus.in_valid & ~r_full;
  assign w_pop  = bus.out_ready & ~r_empty;

  // Next occupancy: +1 on push only, -1 on pop only.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push & ~w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (~w_push & w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.in_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == L_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign bus.in_ready  = ~r_full;
  assign bus.out_valid = ~r_empty;
  assign bus.out_data  = r_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.wr_addr   = r_wr_ptr;
  assign bus.count     = r_count;
  assign bus.full      = r_full;
  assign bus.empty     = r_empty;

`ifdef DATABLOCK_FIFO_STATS_EN
  logic [7:0] r_push_total;

  // Push counter; clear has priority over a coincident push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_push_total <= '0;
    else if (stats_clr)
      r_push_total <= '0;
    else if (w_push)
      r_push_total <= r_push_total + 1'b1;
  end

  assign push_total = r_push_total;
`endif

endmodule

// File: tb/tb_datablock_fifo.sv
// Scoreboard bench for datablock_fifo.
// Stats checks compile in when DATABLOCK_FIFO_STATS_EN is defined.
module tb_datablock_fifo;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [1:0] q[$];
  int         m_cnt;
  logic [1:0] m_wr;
  logic [7:0] m_tot;

  datablock_fifo_if #(.WIDTH(2), .AW(2)) bus ();

`ifdef DATABLOCK_FIFO_STATS_EN
  logic       stats_clr;
  logic [7:0] push_total;
`endif

  datablock_fifo #(
    .WIDTH(2), .DEPTH(4), .AW(2)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DATABLOCK_FIFO_STATS_EN
    .stats_clr (stats_clr),
    .push_total(push_total),
`endif
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_wr  = '0;
    m_tot = '0;
  endtask

  task automatic check_state(input string tag);
    logic [1:0] exp_d;
    exp_d = (m_cnt > 0) ? q[0] : 2'b00;
    check({tag, ".count"}, 32'(bus.count), 32'(m_cnt));
    check({tag, ".full"}, 32'(bus.full), 32'(m_cnt == 4));
    check({tag, ".empty"}, 32'(bus.empty), 32'(m_cnt == 0));
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(m_cnt != 4));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_cnt != 0));
    check({tag, ".out_data"}, 32'(bus.out_data), 32'(exp_d));
    check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(m_wr));
`ifdef DATABLOCK_FIFO_STATS_EN
    check({tag, ".push_total"}, 32'(push_total), 32'(m_tot));
`endif
  endtask

  // One cycle: drive at negedge, check pre-edge state,
  // advance the model to match the coming rising edge.
  task automatic cyc(input string tag, input logic v,
                     input logic [1:0] d, input logic r,
                     input logic clr = 1'b0);
    logic push, pop;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
`ifdef DATABLOCK_FIFO_STATS_EN
    stats_clr = clr;
`endif
    check_state(tag);
    push = v && (m_cnt < 4);
    pop  = r && (m_cnt > 0);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(d);
      m_wr = m_wr + 2'd1;
    end
    m_cnt = m_cnt + int'(push) - int'(pop);
    if (clr) m_tot = '0;
    else if (push) m_tot = m_tot + 8'd1;
    @(posedge clk);
  endtask

  initial begin
    logic [1:0] pat [4];
    checks = 0;
    failures = 0;
    pat[0] = 2'b01; pat[1] = 2'b10;
    pat[2] = 2'b11; pat[3] = 2'b00;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef DATABLOCK_FIFO_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    cyc("t1", 1'b0, 2'b00, 1'b0);
    cyc("t1b", 1'b0, 2'b00, 1'b0);

    // 2: fill to full
    for (int i = 0; i < 4; i++)
      cyc("t2", 1'b1, pat[i], 1'b0);

    // 3: push attempts while full are dropped
    for (int i = 0; i < 3; i++)
      cyc("t3", 1'b1, 2'b11, 1'b0);

    // 3a: drain in order
    for (int i = 0; i < 4; i++)
      cyc("t3a", 1'b0, 2'b00, 1'b1);
    cyc("t3a_end", 1'b0, 2'b00, 1'b0);

    // 4: hold count=2 with push+pop each cycle
    cyc("t4_fill", 1'b1, 2'b11, 1'b0);
    cyc("t4_fill", 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc("t4", 1'b1, 2'(i), 1'b1);
    for (int i = 0; i < 2; i++)
      cyc("t4_drain", 1'b0, 2'b00, 1'b1);

    // 5: push into empty with out_ready high
    cyc("t5_push", 1'b1, 2'b10, 1'b1);
    cyc("t5_pop", 1'b0, 2'b00, 1'b1);
    cyc("t5_end", 1'b0, 2'b00, 1'b0);

    // 6: asynchronous reset with count=3
    for (int i = 0; i < 3; i++)
      cyc("t6_fill", 1'b1, pat[i], 1'b0);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check_state("t6_pre");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("t6_async");
    @(posedge clk);
    #1 check_state("t6_held");
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    cyc("t6_after", 1'b0, 2'b00, 1'b0);

`ifdef DATABLOCK_FIFO_STATS_EN
    // 6a: 260 pushes wrap the counter to 4
    for (int i = 0; i < 260; i++)
      cyc("t6a", 1'b1, 2'(i), 1'b1);
    cyc("t6a_end", 1'b0, 2'b00, 1'b1);
    check("t6a_total", 32'(push_total), 32'd4);
    // clear beats a coincident push
    cyc("t6a_clr", 1'b1, 2'b01, 1'b0, 1'b1);
    cyc("t6a_clr_end", 1'b0, 2'b00, 1'b1);
    cyc("t6a_idle", 1'b0, 2'b00, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
